emission_sweeper: RTL and testbench
===================================

# emission_sweeper

Initiator for the emission-matrix lookup. It accepts one word index at a time, issues POS indices 0..POS_NUM-1 to the emission matrix with the word held constant, and streams back one (POS, probability) beat per POS. A running argmax across the sweep is reported with the final beat. It sits between the word-sequence front end and the Viterbi trellis update, and supplies the emission column for each observation.

## Interface
- WORD_NUM_BIT, 8, word index width
- POS_NUM_BIT, 4, POS index width
- POS_NUM, 11, number of POS tags swept per word
- MAX_WORD, 95, number of valid word indices (legal range 0..MAX_WORD-1)
- P_SIZE, 32, probability width (unsigned fixed-point; larger means more likely)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- word_in_valid  in  1  upstream word available
- word_in_ready  out  1  block idle; registered
- word_in  in  WORD_NUM_BIT  word index
- mx_word  out  WORD_NUM_BIT  word driven to emission matrix; registered
- mx_pos  out  POS_NUM_BIT  POS driven to emission matrix; registered
- mx_emiss_p  in  P_SIZE  matrix response (combinational from mx_word/mx_pos)
- mx_pos_echo  in  POS_NUM_BIT  POS echoed by matrix
- out_valid / out_ready  out / in  1  result-stream handshake
- out_pos  out  POS_NUM_BIT  POS of this beat
- out_p  out  P_SIZE  emission probability of this beat
- out_last  out  1  final beat of the sweep
- out_err  out  1  out-of-range word or echo mismatch on this beat
- best_pos / best_p  out  POS_NUM_BIT / P_SIZE  argmax over beats emitted so far in this sweep

## Operation
- States: IDLE, SWEEP, DRAIN, ERR.
- IDLE: word_in_ready=1. A handshake occurs when valid and ready are both 1 on an edge. On handshake: ready goes to 0, mx_word takes word_in, mx_pos goes to 0, best_p and best_pos go to 0. If word_in < MAX_WORD, go to SWEEP; otherwise go to ERR.
- advance = !out_valid || out_ready.
- SWEEP, on an edge where advance is true:
  - out_pos takes mx_pos_echo and out_p takes mx_emiss_p; out_valid goes to 1.
  - out_last = (mx_pos == POS_NUM-1).
  - out_err = (mx_pos_echo != mx_pos).
  - If mx_pos is 0, or mx_emiss_p is strictly greater than best_p, best takes (mx_pos, mx_emiss_p). On a tie the lower POS is kept.
  - If mx_pos == POS_NUM-1, go to DRAIN; otherwise mx_pos increments.
- SWEEP with advance false: all registers hold. The mx_* outputs stay stable, so the response stays valid.
- ERR: emit a single beat with out_valid=1, out_last=1, out_err=1, out_pos=0, out_p=0, then go to DRAIN. best_* stays 0.
- DRAIN: on the edge where out_valid && out_ready, clear out_valid, set word_in_ready=1, and go to IDLE.
- A beat is held unchanged (all out_* fields) until it is accepted.
- No wrap: mx_pos never exceeds POS_NUM-1.

## Timing
- Reset values: every output is 0, including word_in_ready. State is IDLE.
- word_in_ready rises on the first edge after rst deasserts.
- Reset asserted mid-sweep aborts the sweep immediately. No partial last beat is emitted.
- Word accepted at edge t0:
  - beat k (POS k) is presented after edge t0+1+k when there is no backpressure;
  - the last beat appears after edge t0+POS_NUM;
  - with out_ready held at 1, word_in_ready is high again after edge t0+POS_NUM+1.
- Throughput is 1 beat/cycle. Each stalled cycle adds exactly one cycle to every later beat.
- best_pos and best_p, sampled with the out_last beat, include that beat's own value.

## Structure
- Shared package holds:
  - the POS_NUM, MAX_WORD, P_SIZE, POS_NUM_BIT and WORD_NUM_BIT constants (also used by the matrix and the trellis);
  - the state enum;
  - a result-beat struct {pos, p, last, err}.
- One sub-module is natural: argmax_tracker (compare-and-hold with clear/update enables).

## Test plan
- Word 3, matrix returns p = 0x10·(POS+1), out_ready=1 -> 11 beats on consecutive cycles with out_p 0x10..0xB0; out_last only on POS 10; best = (10, 0xB0); ready high again 12 cycles after the accept edge.
- Word 94 (last legal word), out_ready toggling 1,0,1,0 -> 11 beats, each held stable while stalled; all values correct; total duration 21 cycles.
- Word 95 -> single beat with err=1, last=1, pos=0, p=0; the matrix is never swept beyond POS 0; best = (0, 0).
- Ties: p=0x50 at POS 2 and POS 7, everything else 0x01 -> best_pos=2, best_p=0x50.
- Echo fault: matrix echoes 5 when driven 4 -> out_err=1 on that beat only; the sweep still completes.
- rst pulsed during beat 6 -> all outputs 0 at once; word_in_ready=1 one edge after release; the next word sweeps cleanly from POS 0.

Source files
------------

// File: rtl/emission_sweeper_pkg.sv
`default_nettype none
// ======================================================================
// emission_sweeper_pkg : constants, FSM states and result-beat type
//                        shared by the sweeper, matrix and trellis
// Rev 1.0
// ======================================================================
package emission_sweeper_pkg;

  localparam int WORD_NUM_BIT = 8;
  localparam int POS_NUM_BIT  = 4;
  localparam int POS_NUM      = 11;
  localparam int MAX_WORD     = 95;
  localparam int P_SIZE       = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2,
    S_ERR   = 2'd3
  } sweep_state_t;

  typedef struct packed {
    logic [POS_NUM_BIT-1:0] pos;
    logic [P_SIZE-1:0]      p;
    logic                   last;
    logic                   err;
  } beat_t;

endpackage
`default_nettype wire

// File: rtl/emission_sweeper_argmax_tracker.sv
`default_nettype none
// ======================================================================
// argmax_tracker : running (pos, p) maximum; earliest pos wins on a tie
// Rev 1.0
// ======================================================================
module argmax_tracker
  import emission_sweeper_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clear,
  input  logic                   i_update,
  input  logic                   i_force,
  input  logic [POS_NUM_BIT-1:0] i_pos,
  input  logic [P_SIZE-1:0]      i_p,
  output logic [POS_NUM_BIT-1:0] o_best_pos,
  output logic [P_SIZE-1:0]      o_best_p
);

  logic [POS_NUM_BIT-1:0] r_best_pos;
  logic [P_SIZE-1:0]      r_best_p;

  // strict compare keeps the lower pos when probabilities tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_best_pos <= '0;
      r_best_p   <= '0;
    end else if (i_clear) begin
      r_best_pos <= '0;
      r_best_p   <= '0;
    end else if (i_update && (i_force || (i_p > r_best_p))) begin
      r_best_pos <= i_pos;
      r_best_p   <= i_p;
    end
  end

  assign o_best_pos = r_best_pos;
  assign o_best_p   = r_best_p;

endmodule
`default_nettype wire

// File: rtl/emission_sweeper.sv
`default_nettype none
// ======================================================================
// emission_sweeper : sweeps all POS for one word through the emission
//                    matrix, streams (pos, p) beats and a running argmax
// Rev 1.0
// ======================================================================
module emission_sweeper
  import emission_sweeper_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    word_in_valid,
  output logic                    word_in_ready,
  input  logic [WORD_NUM_BIT-1:0] word_in,
  output logic [WORD_NUM_BIT-1:0] mx_word,
  output logic [POS_NUM_BIT-1:0]  mx_pos,
  input  logic [P_SIZE-1:0]       mx_emiss_p,
  input  logic [POS_NUM_BIT-1:0]  mx_pos_echo,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [POS_NUM_BIT-1:0]  out_pos,
  output logic [P_SIZE-1:0]       out_p,
  output logic                    out_last,
  output logic                    out_err,
  output logic [POS_NUM_BIT-1:0]  best_pos,
  output logic [P_SIZE-1:0]       best_p
);

  localparam logic [WORD_NUM_BIT-1:0] C_MAX_WORD = WORD_NUM_BIT'(MAX_WORD);
  localparam logic [POS_NUM_BIT-1:0]  C_POS_LAST = POS_NUM_BIT'(POS_NUM - 1);

  sweep_state_t            r_state, w_state_nxt;
  logic                    r_ready;
  logic [WORD_NUM_BIT-1:0] r_mx_word;
  logic [POS_NUM_BIT-1:0]  r_mx_pos;
  beat_t                   r_beat, w_beat;
  logic                    r_out_valid;

  logic w_advance, w_pos_last, w_accept, w_capture, w_err_beat, w_release;

  assign w_advance  = !r_out_valid || out_ready;
  assign w_pos_last = (r_mx_pos == C_POS_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_err_beat  = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_ready && word_in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = (word_in < C_MAX_WORD) ? S_SWEEP : S_ERR;
        end
      end
      S_SWEEP: begin
        if (w_advance) begin
          w_capture = 1'b1;
          if (w_pos_last) w_state_nxt = S_DRAIN;
        end
      end
      S_ERR: begin
        w_err_beat  = 1'b1;
        w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_out_valid && out_ready) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_beat = '0;
    if (w_capture) begin
      w_beat.pos  = mx_pos_echo;
      w_beat.p    = mx_emiss_p;
      w_beat.last = w_pos_last;
      w_beat.err  = (mx_pos_echo != r_mx_pos);
    end else begin
      w_beat.last = 1'b1;
      w_beat.err  = 1'b1;
    end
  end

  // ready is high exactly while the FSM rests in IDLE (one edge after reset)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready     <= 1'b0;
      r_mx_word   <= '0;
      r_mx_pos    <= '0;
      r_beat      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == S_IDLE);
      if (w_accept) begin
        r_mx_word <= word_in;
        r_mx_pos  <= '0;
      end else if (w_capture && !w_pos_last) begin
        r_mx_pos <= r_mx_pos + 1'b1;
      end
      if (w_capture || w_err_beat) begin
        r_beat      <= w_beat;
        r_out_valid <= 1'b1;
      end else if (w_release) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  argmax_tracker u_argmax (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_accept),
    .i_update   (w_capture),
    .i_force    (r_mx_pos == '0),
    .i_pos      (r_mx_pos),
    .i_p        (mx_emiss_p),
    .o_best_pos (best_pos),
    .o_best_p   (best_p)
  );

  assign word_in_ready = r_ready;
  assign mx_word       = r_mx_word;
  assign mx_pos        = r_mx_pos;
  assign out_valid     = r_out_valid;
  assign out_pos       = r_beat.pos;
  assign out_p         = r_beat.p;
  assign out_last      = r_beat.last;
  assign out_err       = r_beat.err;

endmodule
`default_nettype wire

// File: tb/tb_emission_sweeper.sv
`default_nettype none
// ======================================================================
// tb_emission_sweeper : directed sweeps against a queue-based beat model
// Rev 1.0
// ======================================================================
module tb_emission_sweeper;
  import emission_sweeper_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    word_in_valid = 1'b0;
  logic                    word_in_ready;
  logic [WORD_NUM_BIT-1:0] word_in = '0;
  logic [WORD_NUM_BIT-1:0] mx_word;
  logic [POS_NUM_BIT-1:0]  mx_pos;
  logic [P_SIZE-1:0]       mx_emiss_p;
  logic [POS_NUM_BIT-1:0]  mx_pos_echo;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic [POS_NUM_BIT-1:0]  out_pos;
  logic [P_SIZE-1:0]       out_p;
  logic                    out_last;
  logic                    out_err;
  logic [POS_NUM_BIT-1:0]  best_pos;
  logic [P_SIZE-1:0]       best_p;

  always #5 clk = ~clk;

  emission_sweeper dut (
    .clk(clk), .rst(rst),
    .word_in_valid(word_in_valid), .word_in_ready(word_in_ready), .word_in(word_in),
    .mx_word(mx_word), .mx_pos(mx_pos), .mx_emiss_p(mx_emiss_p), .mx_pos_echo(mx_pos_echo),
    .out_valid(out_valid), .out_ready(out_ready), .out_pos(out_pos), .out_p(out_p),
    .out_last(out_last), .out_err(out_err), .best_pos(best_pos), .best_p(best_p)
  );

  // emission matrix stand-in: table lookup plus an optional echo fault at POS 4
  logic [P_SIZE-1:0] p_tab [16];
  bit                echo_fault = 1'b0;
  assign mx_emiss_p  = p_tab[mx_pos];
  assign mx_pos_echo = (echo_fault && mx_pos == 4'd4) ? 4'd5 : mx_pos;

  typedef struct {
    logic [POS_NUM_BIT-1:0] pos;
    logic [P_SIZE-1:0]      p;
    logic                   last;
    logic                   err;
    logic [POS_NUM_BIT-1:0] bpos;
    logic [P_SIZE-1:0]      bp;
  } exp_t;

  exp_t                   exp_q[$];
  int                     n_chk = 0;
  int                     n_fail = 0;
  bit                     started = 1'b0;
  int                     max_pos_seen = 0;
  logic [POS_NUM_BIT-1:0] last_bpos = '0;
  logic [P_SIZE-1:0]      last_bp = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // expected beats for one word: prefix argmax, earliest POS wins on ties
  task automatic push_word(input int w);
    exp_t e;
    int   bi;
    logic [P_SIZE-1:0] bv;
    if (w >= MAX_WORD) begin
      e.pos = '0; e.p = '0; e.last = 1'b1; e.err = 1'b1; e.bpos = '0; e.bp = '0;
      exp_q.push_back(e);
      return;
    end
    bi = 0;
    bv = p_tab[0];
    for (int k = 0; k < POS_NUM; k++) begin
      if (p_tab[k] > bv) begin
        bi = k;
        bv = p_tab[k];
      end
      e.pos  = (echo_fault && k == 4) ? 4'd5 : 4'(k);
      e.p    = p_tab[k];
      e.last = (k == POS_NUM - 1);
      e.err  = (echo_fault && k == 4);
      e.bpos = 4'(bi);
      e.bp   = bv;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (int'(mx_pos) > max_pos_seen) max_pos_seen = int'(mx_pos);
    if (rst) begin
      exp_q.delete();
      started = 1'b0;
    end else begin
      if (word_in_valid && word_in_ready) push_word(int'(word_in));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(out_valid), 64'(0));
        end else begin
          chk("out_pos",  64'(out_pos),  64'(exp_q[0].pos));
          chk("out_p",    64'(out_p),    64'(exp_q[0].p));
          chk("out_last", 64'(out_last), 64'(exp_q[0].last));
          chk("out_err",  64'(out_err),  64'(exp_q[0].err));
          chk("best_pos", 64'(best_pos), 64'(exp_q[0].bpos));
          chk("best_p",   64'(best_p),   64'(exp_q[0].bp));
          if (out_ready) begin
            if (out_last) begin
              last_bpos = best_pos;
              last_bp   = best_p;
            end
            void'(exp_q.pop_front());
            started = (exp_q.size() != 0);
          end
        end
      end else if (started) begin
        chk("beat_gap", 64'(out_valid), 64'(1));
      end
    end
  end

  // toggle=1 drives out_ready 1,0,1,0.. on edges t0+1, t0+2, ..
  task automatic run_word(input string tag, input logic [WORD_NUM_BIT-1:0] w, input bit toggle,
                          input int exp_first, input int exp_done);
    int first;
    int done;
    int n;
    first = -1;
    done  = -1;
    n = 0;
    while (!word_in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_ready_in"}, 64'(word_in_ready), 64'(1));
    word_in       = w;
    word_in_valid = 1'b1;
    @(posedge clk); #1;
    word_in_valid = 1'b0;
    max_pos_seen  = int'(mx_pos);
    out_ready     = 1'b1;
    for (n = 1; n < 100 && done < 0; n++) begin
      @(posedge clk); #1;
      out_ready = toggle ? (n % 2 == 0) : 1'b1;
      if (out_valid && first < 0) first = n;
      if (word_in_ready) done = n;
    end
    out_ready = 1'b1;
    chk({tag, "_first_beat_edge"}, 64'(first), 64'(exp_first));
    chk({tag, "_ready_again_edge"}, 64'(done), 64'(exp_done));
    chk({tag, "_model_drained"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    for (int k = 0; k < 16; k++) p_tab[k] = 32'h10 * (k + 1);

    @(posedge clk); #1;
    chk("rst_ready", 64'(word_in_ready), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_mx_pos", 64'(mx_pos), 64'(0));
    chk("rst_best_p", 64'(best_p), 64'(0));
    @(posedge clk); #3 rst = 1'b0;
    #1 chk("ready_low_before_edge", 64'(word_in_ready), 64'(0));
    @(posedge clk); #1;
    chk("ready_after_release", 64'(word_in_ready), 64'(1));

    // word 3, ramp 0x10..0xB0, no backpressure
    run_word("ramp", 8'd3, 1'b0, 1, 12);
    chk("ramp_best_pos", 64'(last_bpos), 64'(10));
    chk("ramp_best_p", 64'(last_bp), 64'hB0);

    // word 94 with alternating out_ready: last beat after t0+21
    for (int k = 0; k < 16; k++) p_tab[k] = 32'h1000 + 32'((k * 37) % 11);
    run_word("stall", 8'd94, 1'b1, 1, 23);
    chk("stall_best_pos", 64'(last_bpos), 64'(8));
    chk("stall_best_p", 64'(last_bp), 64'h100A);

    // word 95 is out of range
    run_word("oob", 8'd95, 1'b0, 1, 2);
    chk("oob_mx_word", 64'(mx_word), 64'd95);
    chk("oob_max_pos", 64'(max_pos_seen), 64'(0));
    chk("oob_best_p", 64'(last_bp), 64'(0));

    // tie between POS 2 and POS 7
    for (int k = 0; k < 16; k++) p_tab[k] = 32'h01;
    p_tab[2] = 32'h50;
    p_tab[7] = 32'h50;
    run_word("tie", 8'd10, 1'b0, 1, 12);
    chk("tie_best_pos", 64'(last_bpos), 64'(2));
    chk("tie_best_p", 64'(last_bp), 64'h50);

    // echo fault on POS 4
    for (int k = 0; k < 16; k++) p_tab[k] = 32'h10 * (k + 1);
    echo_fault = 1'b1;
    run_word("echo", 8'd20, 1'b0, 1, 12);
    echo_fault = 1'b0;

    // reset while beat 6 is presented
    word_in       = 8'd3;
    word_in_valid = 1'b1;
    @(posedge clk); #1;
    word_in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 chk("pre_rst_beat6_pos", 64'(out_pos), 64'(6));
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", 64'(word_in_ready), 64'(0));
    chk("arst_mx_word", 64'(mx_word), 64'(0));
    chk("arst_mx_pos", 64'(mx_pos), 64'(0));
    chk("arst_valid", 64'(out_valid), 64'(0));
    chk("arst_out_pos", 64'(out_pos), 64'(0));
    chk("arst_out_p", 64'(out_p), 64'(0));
    chk("arst_best", 64'({best_pos, best_p}), 64'(0));
    @(posedge clk); #3 rst = 1'b0;
    #1 chk("arst_ready_before_edge", 64'(word_in_ready), 64'(0));
    @(posedge clk); #1;
    chk("arst_ready_after_edge", 64'(word_in_ready), 64'(1));
    chk("arst_no_partial_beat", 64'(out_valid), 64'(0));

    run_word("post_rst", 8'd3, 1'b0, 1, 12);
    chk("post_rst_best_p", 64'(last_bp), 64'hB0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
